// File: rtl/weight_fetch_arbiter.sv
// Round-robin arbiter that lets one of four neuron units stream a burst of
// weights out of a 128-entry weight ROM. A burst is granted from IDLE, reads
// one ROM word per cycle in BURST, and closes with a single DRAIN cycle while
// the last registered word is delivered.
module weight_fetch_arbiter #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [31:0]          base_addr,
    input  logic [4*LEN_W-1:0]   burst_len,
    output logic [3:0]           grant,
    output logic [7:0]           rom_addr,
    output logic                 rom_en,
    input  logic [DATA_W-1:0]    rom_data,
    output logic [DATA_W-1:0]    wdata,
    output logic                 wvalid,
    output logic                 wlast,
    output logic [1:0]           wdst,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Burst context captured at grant time; the ROM only has 128 words so the
    // address register is 7 bits and wraps naturally.
    logic [6:0]        addr_p0;
    logic [LEN_W-1:0]  cnt_p0;
    logic [1:0]        last_win;

    logic [1:0]        win;
    logic              win_vld;
    logic [1:0]        cand;

    // ROM read data registered one cycle after the address was presented.
    logic [DATA_W-1:0] wdata_p1;
    logic              vld_p1;
    logic              last_p1;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win     = 2'd0;
        win_vld = 1'b0;
        cand    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = last_win + 2'd1 + 2'(i);
            if (!win_vld && req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    // Next-state logic and the state-decoded ROM/busy outputs.
    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        rom_addr  = 8'd0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (win_vld) state_nxt = BURST;
            end
            BURST: begin
                rom_en   = 1'b1;
                rom_addr = {1'b0, addr_p0};
                if (cnt_p0 == '0) state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Grant/context capture, address walk and the registered weight stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= 2'd3;
            grant    <= 4'd0;
            wdst     <= 2'd0;
            addr_p0  <= 7'd0;
            cnt_p0   <= '0;
            wdata_p1 <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        last_win <= win;
                        grant    <= 4'b0001 << win;
                        wdst     <= win;
                        addr_p0  <= base_addr[{win, 3'b000} +: 7];
                        cnt_p0   <= burst_len[LEN_W*win +: LEN_W];
                    end
                end
                BURST: begin
                    wdata_p1 <= rom_data;
                    vld_p1   <= 1'b1;
                    last_p1  <= (cnt_p0 == '0);
                    addr_p0  <= addr_p0 + 7'd1;
                    if (cnt_p0 != '0) cnt_p0 <= cnt_p0 - 1'b1;
                end
                DRAIN: begin
                    grant <= 4'd0;
                end
                default: begin
                    grant <= 4'd0;
                end
            endcase
        end
    end

    assign wdata  = wdata_p1;
    assign wvalid = vld_p1;
    assign wlast  = last_p1;

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Testbench for weight_fetch_arbiter: a schedule-level reference model
// predicts per-cycle grant/ROM activity and queues the expected weight words;
// a monitor compares the DUT against both every cycle.
module tb_weight_fetch_arbiter;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;
    localparam int BL_W   = 4 * LEN_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        req = 4'd0;
    logic [31:0]       base_addr = 32'd0;
    logic [BL_W-1:0]   burst_len = '0;
    logic [3:0]        grant;
    logic [7:0]        rom_addr;
    logic              rom_en;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wlast;
    logic [1:0]        wdst;
    logic              busy;

    logic [DATA_W-1:0] rom [128];

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [1:0]        dst;
        logic              last;
    } exp_t;

    exp_t q[$];

    // Reference schedule: m_k counts cycles since the grant edge (0 = idle).
    int m_k = 0;
    int m_len = 1;
    int m_base = 0;
    int m_w = 0;
    int m_last = 3;

    weight_fetch_arbiter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .grant     (grant),
        .rom_addr  (rom_addr),
        .rom_en    (rom_en),
        .rom_data  (rom_data),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wlast     (wlast),
        .wdst      (wdst),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign rom_data = rom_en ? rom[rom_addr[6:0]] : '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitrate from idle, then run for len+1 busy cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k    = 0;
            m_last = 3;
            q.delete();
        end else if (m_k == 0) begin
            if (req != 4'd0) begin
                for (int i = 1; i <= 4; i++) begin
                    if (req[(m_last + i) % 4]) begin
                        m_w = (m_last + i) % 4;
                        break;
                    end
                end
                m_last = m_w;
                m_len  = int'(burst_len[LEN_W*m_w +: LEN_W]) + 1;
                m_base = int'(base_addr[8*m_w +: 8]) % 128;
                for (int i = 0; i < m_len; i++)
                    q.push_back('{d: rom[(m_base + i) % 128], dst: 2'(m_w), last: (i == m_len - 1)});
                m_k = 1;
            end
        end else if (m_k == m_len + 1) begin
            m_k = 0;
        end else begin
            m_k++;
        end
    end

    // Monitor: per-cycle control checks plus scoreboard pop on each wvalid.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            chk("grant", {28'd0, grant}, (m_k != 0) ? (32'd1 << m_w) : 32'd0);
            chk("busy", {31'd0, busy}, {31'd0, m_k != 0});
            chk("rom_en", {31'd0, rom_en}, {31'd0, (m_k >= 1) && (m_k <= m_len)});
            chk("rom_addr", {24'd0, rom_addr},
                ((m_k >= 1) && (m_k <= m_len)) ? 32'((m_base + m_k - 1) % 128) : 32'd0);
            chk("wvalid", {31'd0, wvalid}, {31'd0, m_k >= 2});
            if (wvalid) begin
                if (q.size() == 0) begin
                    chk("wvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("wdata", {24'd0, wdata}, {24'd0, e.d});
                    chk("wdst", {30'd0, wdst}, {30'd0, e.dst});
                    chk("wlast", {31'd0, wlast}, {31'd0, e.last});
                end
            end else begin
                chk("wlast_no_valid", {31'd0, wlast}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant();
        bit ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (grant != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [3:0] seen [5];
        logic [3:0] prev;
        int         ns;

        for (int i = 0; i < 128; i++) rom[i] = DATA_W'($urandom);

        // Reset values while rst_n is held low.
        #3;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
        chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
        chk("rst_wlast", {31'd0, wlast}, 32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'd0);
        chk("rst_wdst", {30'd0, wdst}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Round robin with all four requesting single-word bursts.
        burst_len = '0;
        base_addr = 32'h30201000;
        req = 4'b1111;
        prev = 4'd0;
        ns = 0;
        for (int c = 0; c < 40 && ns < 5; c++) begin
            @(negedge clk);
            if (grant != 4'd0 && prev == 4'd0) begin
                seen[ns] = grant;
                ns++;
            end
            prev = grant;
        end
        chk("rr_count", 32'(ns), 32'd5);
        chk("rr_0", {28'd0, seen[0]}, 32'h1);
        chk("rr_1", {28'd0, seen[1]}, 32'h2);
        chk("rr_2", {28'd0, seen[2]}, 32'h4);
        chk("rr_3", {28'd0, seen[3]}, 32'h8);
        chk("rr_4", {28'd0, seen[4]}, 32'h1);
        req = 4'd0;
        wait_idle();

        // Single three-word burst from requester 0 (last winner was 0, only 0 asks).
        rom[16] = 8'hA1;
        rom[17] = 8'hA2;
        rom[18] = 8'hA3;
        base_addr = 32'h00000010;
        burst_len = BL_W'(2);
        req = 4'b0001;
        wait_grant();
        req = 4'd0;
        wait_idle();

        // Address wrap: base 0xFF behaves as 0x7F and wraps to 0x00.
        base_addr = 32'h00FF0000;
        burst_len = BL_W'(16'h0100);
        req = 4'b0100;
        wait_grant();
        req = 4'd0;
        wait_idle();

        // Inputs change two cycles into a four-word burst.
        base_addr = 32'h00004000;
        burst_len = BL_W'(16'h0030);
        req = 4'b0010;
        wait_grant();
        @(posedge clk);
        #2;
        req = 4'd0;
        base_addr = 32'h00002000;
        burst_len = '1;
        wait_idle();

        // Reset in the middle of an eight-word burst.
        base_addr = 32'h00000050;
        burst_len = BL_W'(7);
        req = 4'b0001;
        wait_grant();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req = 4'b0011;
        #1;
        chk("mid_rst_grant", {28'd0, grant}, 32'd0);
        chk("mid_rst_rom_en", {31'd0, rom_en}, 32'd0);
        chk("mid_rst_wvalid", {31'd0, wvalid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_wdata", {24'd0, wdata}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_grant();
        chk("post_rst_winner", {28'd0, grant}, 32'h1);
        req = 4'd0;
        wait_idle();

        // Randomized traffic.
        for (int it = 0; it < 150; it++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = 4'd0;
            base_addr = $urandom;
            burst_len = BL_W'($urandom);
            req = r;
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #2;
        end
        req = 4'd0;
        wait_idle();
        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
